// File: rtl/conv_accum_nch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Purpose  : Shared constants, accumulator FSM encoding and the saturation
//            helper for the conv_accum_nch partial-sum combiner.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package conv_pkg;

  localparam int DEF_WIDTH     = 10;
  localparam int DEF_NCH       = 4;
  localparam int DEF_ACC_W     = 24;
  localparam int DEF_SHIFT     = 9;
  localparam int DEF_MAX_BEATS = 64;

  // Accumulator FSM encoding; the enum mirrors the raw constants so older
  // blocks comparing against plain bit patterns keep working.
  localparam logic [0:0] ST_FIRST = 1'b0;
  localparam logic [0:0] ST_ACCUM = 1'b1;

  typedef enum logic [0:0] {
    FIRST = ST_FIRST,
    ACCUM = ST_ACCUM
  } acc_state_e;

  // Clamp a wide signed value to the range of a w-bit signed number.
  // Callers keep w at or below 63.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v,
                                               input int                 w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_accum_nch_if.sv
`default_nettype none
// ============================================================================
// Module   : conv_accum_nch_if
// Purpose  : Stream bundle between the filter array (source), the combiner
//            and the feature-map writer (sink). The master modport is the
//            environment side, the slave modport is the combiner.
// Revision : 1.0 - initial parametrised release
// ============================================================================
interface conv_accum_nch_if
  import conv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NCH*WIDTH-1:0]    in_data;
  logic                    in_last;
  logic signed [WIDTH-1:0] bias;
  logic                    clip;
  logic                    relu;
  logic [7:0]              relu_c;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_ovf;
  logic                    err_len;

  modport master (
    output in_valid, in_data, in_last, bias, clip, relu, relu_c, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, err_len
  );

  modport slave (
    input  in_valid, in_data, in_last, bias, clip, relu, relu_c, out_ready,
    output in_ready, out_valid, out_data, out_ovf, err_len
  );
endinterface
`default_nettype wire

// File: rtl/conv_accum_nch_adder_tree.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_n
// Purpose  : Sign-extending binary adder tree over NCH packed signed inputs
//            with a single registered output. Reusable by pooling blocks.
// Revision : 1.0 - initial release
// ============================================================================
module adder_tree_n
  import conv_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NCH   = DEF_NCH,
  localparam int LVL   = $clog2(NCH),
  localparam int SUM_W = WIDTH + LVL
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [NCH*WIDTH-1:0]    in_data,
  output logic signed [SUM_W-1:0] sum
);

  // Level 0 holds the sign-extended inputs; each later level halves the count.
  for (genvar l = 0; l <= LVL; l++) begin : g_lvl
    localparam int N = NCH >> l;
    logic signed [SUM_W-1:0] v [N];
    if (l == 0) begin : g_leaf
      for (genvar c = 0; c < N; c++) begin : g_c
        assign v[c] = SUM_W'($signed(in_data[c*WIDTH +: WIDTH]));
      end
    end else begin : g_add
      for (genvar c = 0; c < N; c++) begin : g_c
        assign v[c] = g_lvl[l-1].v[2*c] + g_lvl[l-1].v[2*c+1];
      end
    end
  end

  // Register the root sum whenever the pipeline advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum <= '0;
    end else if (en) begin
      sum <= g_lvl[LVL].v[0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_accum_nch.sv
`default_nettype none
// ============================================================================
// Module   : conv_accum_nch
// Purpose  : Sums NCH filter partials per beat, accumulates a channel group
//            (closed by in_last or by the MAX_BEATS limit), adds bias, then
//            requantises, clips/wraps and applies ReLU / leaky ReLU.
//            Pipeline: A (tree sum) -> B (accumulator) -> C (requantise).
// Options  : CONV_ACCUM_ROUND_EN - round half up before the requantise shift
//            (default build floors).
// Revision : 1.0 - initial parametrised release
// ============================================================================
module conv_accum_nch
  import conv_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NCH       = DEF_NCH,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int SHIFT     = DEF_SHIFT,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input logic             clk,
  input logic             reset,
  conv_accum_nch_if.slave bus
);

  localparam int TREE_W = WIDTH + $clog2(NCH);
  localparam int CNT_W  = $clog2(MAX_BEATS + 1);

  // Single global stall: nothing moves while a result waits downstream.
  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // ---------------------------------------------------------------- stage A
  logic signed [TREE_W-1:0] a_sum;
  logic                     a_valid;
  logic                     a_last;
  logic signed [WIDTH-1:0]  a_bias;
  logic                     a_clip;
  logic                     a_relu;
  logic [7:0]               a_relu_c;

  adder_tree_n #(
    .WIDTH (WIDTH),
    .NCH   (NCH)
  ) u_tree (
    .clk     (clk),
    .reset   (reset),
    .en      (adv),
    .in_data (bus.in_data),
    .sum     (a_sum)
  );

  // Carry beat sideband alongside the tree sum; stage B decides which to use.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_valid  <= 1'b0;
      a_last   <= 1'b0;
      a_bias   <= '0;
      a_clip   <= 1'b0;
      a_relu   <= 1'b0;
      a_relu_c <= '0;
    end else if (adv) begin
      a_valid  <= bus.in_valid;
      a_last   <= bus.in_last;
      a_bias   <= bus.bias;
      a_clip   <= bus.clip;
      a_relu   <= bus.relu;
      a_relu_c <= bus.relu_c;
    end
  end

  // ---------------------------------------------------------------- stage B
  logic [0:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic                    grp_ovf;
  logic                    b_close;
  logic                    b_clip;
  logic                    b_relu;
  logic [7:0]              b_relu_c;
  logic                    err_len;

  logic                    first;
  logic signed [63:0]      acc_ext;
  logic signed [63:0]      base_ext;
  logic signed [63:0]      raw_ext;
  logic signed [63:0]      sat_ext;
  logic                    sat_hit;
  logic [CNT_W-1:0]        beat_n;
  logic                    force_close;
  logic                    close;

  assign first       = (state == ST_FIRST);
  assign acc_ext     = 64'(acc);
  // First beat of a group starts from the scaled bias instead of the old sum.
  assign base_ext    = first ? (64'(a_bias) <<< SHIFT) : acc_ext;
  assign raw_ext     = base_ext + 64'(a_sum);
  assign sat_ext     = sat_s(raw_ext, ACC_W);
  assign sat_hit     = (sat_ext != raw_ext);
  assign beat_n      = cnt + CNT_W'(1);
  assign force_close = !a_last && (beat_n == CNT_W'(MAX_BEATS));
  assign close       = a_last || force_close;

  // Accumulator FSM: only valid stage-A beats change the group state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_FIRST;
      cnt      <= '0;
      acc      <= '0;
      grp_ovf  <= 1'b0;
      b_close  <= 1'b0;
      b_clip   <= 1'b0;
      b_relu   <= 1'b0;
      b_relu_c <= '0;
      err_len  <= 1'b0;
    end else if (adv) begin
      b_close <= a_valid && close;
      if (a_valid) begin
        acc      <= sat_ext[ACC_W-1:0];
        grp_ovf  <= (first ? 1'b0 : grp_ovf) | sat_hit;
        b_clip   <= a_clip;
        b_relu   <= a_relu;
        b_relu_c <= a_relu_c;
        if (close) begin
          state <= ST_FIRST;
          cnt   <= '0;
        end else begin
          state <= ST_ACCUM;
          cnt   <= beat_n;
        end
        if (force_close) begin
          err_len <= 1'b1;
        end
      end
    end
  end

  assign bus.err_len = err_len;

  // ---------------------------------------------------------------- stage C
  logic signed [63:0]      pre_ext;
  logic signed [ACC_W-1:0] pre_acc;
  logic signed [ACC_W-1:0] s_val;
  logic signed [63:0]      clip_ext;
  logic signed [WIDTH-1:0] res;
  logic signed [WIDTH+8:0] prod;
  logic signed [WIDTH+8:0] leaky;
  logic signed [WIDTH-1:0] res_out;

`ifdef CONV_ACCUM_ROUND_EN
  assign pre_ext = sat_s(acc_ext + (64'sd1 <<< (SHIFT - 1)), ACC_W);
`else
  assign pre_ext = acc_ext;
`endif
  assign pre_acc  = pre_ext[ACC_W-1:0];
  assign s_val    = pre_acc >>> SHIFT;
  assign clip_ext = sat_s(64'(s_val), WIDTH);
  assign res      = b_clip ? clip_ext[WIDTH-1:0] : s_val[WIDTH-1:0];
  // Q0.8 slope multiply; arithmetic shift floors toward minus infinity.
  assign prod     = (WIDTH+9)'(res) * (WIDTH+9)'($signed({1'b0, b_relu_c}));
  assign leaky    = prod >>> 8;
  assign res_out  = (b_relu && res[WIDTH-1]) ? leaky[WIDTH-1:0] : res;

  logic unused_bits;
  assign unused_bits = ^{pre_ext[63:ACC_W], clip_ext[63:WIDTH],
                         leaky[WIDTH+8:WIDTH], sat_ext[63:ACC_W]};

  logic                    out_valid;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_ovf;

  // Output register: loads only when a group closes, holds under stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= b_close;
      if (b_close) begin
        out_data <= res_out;
        out_ovf  <= grp_ovf;
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_ovf   = out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_conv_accum_nch.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_accum_nch
// Purpose  : Scoreboard bench for conv_accum_nch (MAX_BEATS reduced to 6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_accum_nch;
  import conv_pkg::*;

  localparam int WIDTH     = 10;
  localparam int NCH       = 4;
  localparam int ACC_W     = 24;
  localparam int SHIFT     = 9;
  localparam int MAX_BEATS = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv_accum_nch_if #(.WIDTH(WIDTH), .NCH(NCH)) bus ();

  conv_accum_nch #(
    .WIDTH     (WIDTH),
    .NCH       (NCH),
    .ACC_W     (ACC_W),
    .SHIFT     (SHIFT),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    longint data;
    bit     ovf;
    int     acc_cyc;
  } exp_t;
  exp_t sb[$];

  // Reference model state
  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_ovf = 0;

  function automatic longint sat_m(input longint v, input int w);
    longint hi = (longint'(1) << (w - 1)) - 1;
    longint lo = -hi - 1;
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic longint floor_div(input longint a, input int sh);
    longint d = longint'(1) << sh;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic longint requant(input longint a, input bit cl, input bit rl, input int rc);
    longint pre, s, r;
`ifdef CONV_ACCUM_ROUND_EN
    pre = sat_m(a + (longint'(1) << (SHIFT - 1)), ACC_W);
`else
    pre = a;
`endif
    s = floor_div(pre, SHIFT);
    if (cl) begin
      r = sat_m(s, WIDTH);
    end else begin
      r = ((s % 1024) + 1024) % 1024;
      if (r >= 512) r -= 1024;
    end
    if (rl && r < 0) r = floor_div(r * rc, 8);
    return r;
  endfunction

  // Drive one beat (channel c = v + c*d), wait for acceptance, update model.
  task automatic beat(input int v, input int d, input bit last, input int b,
                      input bit cl, input bit rl, input int rc);
    int t = 0;
    longint raw, sum = 0;
    exp_t e;
    for (int c = 0; c < NCH; c++) begin
      bus.in_data[c*WIDTH +: WIDTH] = WIDTH'(v + c * d);
      sum += v + c * d;
    end
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    bus.bias     = WIDTH'(b);
    bus.clip     = cl;
    bus.relu     = rl;
    bus.relu_c   = 8'(rc);
    do begin
      @(negedge clk);
      t++;
    end while (!bus.in_ready && t < 100);
    if (!bus.in_ready) check_val("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (m_cnt == 0) begin
      raw   = b * (longint'(1) << SHIFT) + sum;
      m_ovf = 1'b0;
    end else begin
      raw = m_acc + sum;
    end
    m_acc = sat_m(raw, ACC_W);
    if (m_acc != raw) m_ovf = 1'b1;
    m_cnt++;
    if (last || m_cnt == MAX_BEATS) begin
      e.data    = requant(m_acc, cl, rl, rc);
      e.ovf     = m_ovf;
      e.acc_cyc = cyc;
      sb.push_back(e);
      m_cnt = 0;
    end
  endtask

  int last_lat = -1;
  int last_pop = 0;
  int prev_pop = 0;

  // Output monitor: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("out_data", bus.out_data, e.data);
        check_val("out_ovf", bus.out_ovf, e.ovf);
        last_lat = cyc - e.acc_cyc;
        prev_pop = last_pop;
        last_pop = cyc;
      end
    end
  end

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) check_val("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    longint hold;
    int     t;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.bias      = '0;
    bus.clip      = 1'b0;
    bus.relu      = 1'b0;
    bus.relu_c    = '0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_data", bus.out_data, 0);
    check_val("rst_out_ovf", bus.out_ovf, 0);
    check_val("rst_err_len", bus.err_len, 0);
    check_val("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single beat, latency
    beat(256, 0, 1, 0, 1, 0, 0);
    wait_drain();
    check_val("latency", last_lat, 2);

    // Clip vs wrap
    beat(511, 0, 1, 511, 1, 0, 0);
    beat(511, 0, 1, 511, 0, 0, 0);
    // Leaky / plain ReLU / bypass
    beat(-256, 0, 1, -100, 1, 1, 64);
    beat(-256, 0, 1, -100, 1, 1, 0);
    beat(-256, 0, 1, -100, 1, 0, 64);
    wait_drain();

    // Multi-beat group under backpressure; non-first bias and non-last modes are noise
    bus.out_ready = 1'b0;
    beat(128, 0, 0, 0, 0, 1, 5);
    beat(128, 0, 0, 77, 0, 1, 5);
    beat(128, 0, 0, 77, 0, 1, 5);
    beat(128, 0, 0, 77, 0, 1, 5);
    beat(128, 0, 1, 77, 1, 0, 0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.out_valid && t < 20);
    check_val("stall_valid", bus.out_valid, 1);
    hold = (sb.size() > 0) ? sb[0].data : -9999;
    for (int i = 0; i < 4; i++) begin
      check_val("stall_in_ready", bus.in_ready, 0);
      check_val("stall_hold", bus.out_data, hold);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();

    // Back-to-back groups with mixed channel values
    beat(100, 3, 1, 10, 1, 0, 0);
    beat(-50, -7, 1, -3, 0, 1, 200);
    wait_drain();
    check_val("no_bubble", last_pop - prev_pop, 1);

    // Rounding-sensitive values
    beat(192, 0, 1, 0, 1, 0, 0);
    beat(-192, 0, 1, 0, 1, 0, 0);
    wait_drain();

    // Over-long group forces a close and sets the sticky error
    check_val("err_before", bus.err_len, 0);
    for (int i = 0; i < MAX_BEATS; i++) beat(64, 0, 0, 0, 1, 0, 0);
    wait_drain();
    check_val("err_set", bus.err_len, 1);
    beat(64, 0, 1, 0, 1, 0, 0);
    wait_drain();
    check_val("err_sticky", bus.err_len, 1);

    // Reset mid-group discards the partial accumulation
    beat(200, 0, 0, 100, 1, 0, 0);
    beat(200, 0, 0, 100, 1, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
    check_val("rst2_out_valid", bus.out_valid, 0);
    check_val("rst2_err_len", bus.err_len, 0);
    repeat (5) @(posedge clk);
    #1;
    beat(10, 1, 1, -5, 1, 0, 0);
    wait_drain();

    repeat (5) @(posedge clk);
    check_val("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
